native_console_tx: RTL and testbench

NATIVE_CONSOLE_TX -- requirements
Module: native_console_tx

---
 rtl/native_console_pkg.sv | 33 +++
 rtl/native_console_tx_sync_fifo.sv | 54 +++++
 rtl/native_console_tx.sv | 154 +++++++++++++++
 tb/tb_native_console_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/native_console_pkg.sv
// Shared definitions for the native-bus console transmitter: register map,
// STATUS layout and transmitter state encoding.
package native_console_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_RSVD0  = 4'h8;
    localparam logic [3:0] OFF_RSVD1  = 4'hC;

    localparam int unsigned STAT_BUSY      = 32'd0;
    localparam int unsigned STAT_FULL      = 32'd1;
    localparam int unsigned STAT_EMPTY     = 32'd2;
    localparam int unsigned STAT_COUNT_LSB = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] status_word(input logic busy, input logic full,
                                               input logic empty, input logic [7:0] count);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[STAT_BUSY]             = busy;
        w[STAT_FULL]             = full;
        w[STAT_EMPTY]            = empty;
        w[STAT_COUNT_LSB +: 8]   = count;
        return w;
    endfunction

endpackage

// File: rtl/native_console_tx_sync_fifo.sv
// Small synchronous FIFO with a combinational head output; the consumer sees
// the oldest entry on rdata whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == (AW+1)'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count    <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/native_console_tx.sv
// Memory-mapped console transmitter: native-bus register window feeding a
// byte FIFO that drains through an 8N1 UART shifter.
module native_console_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        txd,
    output logic        tx_irq
);
    import native_console_pkg::*;

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    logic          hit_s;
    logic [3:0]    reg_off_s;
    logic          data_wr_s;
    logic          accept_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [7:0]    fifo_head_s;
    logic [CW-1:0] fifo_count_s;
    logic [31:0]   read_value_s;
    tx_state_e     state_r;
    logic [15:0]   baud_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          unused_s;

    assign unused_s  = ^{mem_wdata[31:8], mem_addr[1:0]};
    assign hit_s     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_off_s = {mem_addr[3:2], 2'b00};
    assign data_wr_s = (reg_off_s == OFF_DATA) && mem_wstrb[0];
    // A DATA write against a full FIFO is held off until a slot frees up.
    assign accept_s    = hit_s && !mem_ready && !(data_wr_s && fifo_full_s);
    assign fifo_push_s = accept_s && data_wr_s;
    assign fifo_pop_s  = !fifo_empty_s &&
                         ((state_r == ST_IDLE) || ((state_r == ST_STOP) && (baud_r == 16'd0)));

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .wdata (mem_wdata[7:0]),
        .pop   (fifo_pop_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Read-data mux: only a STATUS read returns non-zero data.
    always_comb begin
        read_value_s = 32'h0000_0000;
        if ((mem_wstrb == 4'b0000) && (reg_off_s == OFF_STATUS)) begin
            read_value_s = status_word(state_r != ST_IDLE, fifo_full_s, fifo_empty_s,
                                       8'(fifo_count_s));
        end else begin
            read_value_s = 32'h0000_0000;
        end
    end

    // Bus response: one-cycle ready pulse, read data held between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0000_0000;
        end else begin
            mem_ready <= accept_s;
            if (accept_s) mem_rdata <= read_value_s;
            else          mem_rdata <= mem_rdata;
        end
    end

    // Transmitter FSM: START, eight data bits LSB first, STOP, each CLK_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            baud_r    <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            txd       <= 1'b1;
            tx_irq    <= 1'b1;
        end else begin
            tx_irq <= fifo_empty_s && (state_r == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r <= ST_START;
                        shift_r <= fifo_head_s;
                        baud_r  <= BAUD_RELOAD;
                        txd     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_r == 16'd0) begin
                        state_r   <= ST_DATA;
                        baud_r    <= BAUD_RELOAD;
                        bit_idx_r <= 3'd0;
                        txd       <= shift_r[0];
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_r == 16'd0) begin
                        baud_r <= BAUD_RELOAD;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                            txd     <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            txd       <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    // Chain straight into the next start bit when more data is queued.
                    if (baud_r == 16'd0) begin
                        if (!fifo_empty_s) begin
                            state_r <= ST_START;
                            shift_r <= fifo_head_s;
                            baud_r  <= BAUD_RELOAD;
                            txd     <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    txd     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_native_console_tx.sv
// Directed plus randomized bench for native_console_tx; a line decoder turns
// txd back into bytes and compares them against the bytes the bus accepted.
module tb_native_console_tx;
    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam int          FRAME      = 10 * CLK_DIV;
    localparam logic [31:0] BASE       = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        txd;
    logic        tx_irq;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         starts_q[$];
    logic       mon_active = 1'b0;
    int         mon_t = 0;
    logic       mon_bit = 1'b0;
    logic [7:0] mon_byte = 8'h00;

    native_console_tx #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .txd       (txd),
        .tx_irq    (tx_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Bus master: caller is at a negedge; returns latency in cycles or -1.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int max_cyc, output logic [31:0] rd, output int lat);
        bit got;
        got = 1'b0;
        rd = 32'h0;
        lat = 0;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        while (!got && lat < max_cyc) begin
            @(negedge clk);
            lat++;
            if (mem_ready === 1'b1) begin
                got = 1'b1;
                rd = mem_rdata;
            end
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        if (!got) lat = -1;
        else if (a[31:4] == BASE[31:4] && a[3:2] == 2'b00 && s[0]) exp_q.push_back(d[7:0]);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (n < 3000 && !(exp_q.size() == 0 && tx_irq === 1'b1 && !mon_active)) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, (exp_q.size() == 0 && tx_irq === 1'b1)}, 32'd1);
    endtask

    // Line decoder: every bit must stay constant for CLK_DIV samples.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
                mon_t = 0;
            end else if (!mon_active) begin
                if (txd === 1'b0) begin
                    mon_active = 1'b1;
                    mon_t = 0;
                    mon_bit = 1'b0;
                    starts_q.push_back(cyc);
                end
            end else begin
                mon_t++;
                if (mon_t % CLK_DIV == 0) begin
                    mon_bit = txd;
                    if (mon_t / CLK_DIV >= 1 && mon_t / CLK_DIV <= 8) mon_byte[mon_t / CLK_DIV - 1] = txd;
                    if (mon_t / CLK_DIV == 9) check("stop_bit", {31'b0, txd}, 32'd1);
                end else begin
                    check("bit_stable", {31'b0, txd}, {31'b0, mon_bit});
                end
                if (mon_t == FRAME - 1) begin
                    mon_active = 1'b0;
                    if (exp_q.size() == 0) check("frame_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                    else check("frame_byte", {24'b0, mon_byte}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int lat;
        logic [7:0] b;

        #1 reset = 1'b1;
        wait_cycles(3);
        check("rst_txd", {31'b0, txd}, 32'd1);
        check("rst_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_irq", {31'b0, tx_irq}, 32'd1);
        reset = 1'b0;
        wait_cycles(2);

        // Single character frame
        bus(BASE, 32'h0000_0041, 4'b0001, 50, rd, lat);
        check("wr41_lat", 32'(lat), 32'd1);
        check("wr41_rdata", rd, 32'h0);
        drain("wr41_drain");

        // STATUS right after two writes: first byte already popped
        bus(BASE, {24'b0, 8'($urandom)}, 4'b0001, 50, rd, lat);
        bus(BASE, {24'b0, 8'($urandom)}, 4'b0001, 50, rd, lat);
        check("wr2_lat", 32'(lat), 32'd2);
        bus(BASE + 32'h4, 32'h0, 4'b0000, 50, rd, lat);
        check("status_after_pop", rd, 32'h0000_0101);
        drain("status_a_drain");

        // STATUS with two bytes queued behind an active frame
        bus(BASE, {24'b0, 8'($urandom)}, 4'b0001, 50, rd, lat);
        wait_cycles(5);
        bus(BASE, {24'b0, 8'($urandom)}, 4'b0001, 50, rd, lat);
        bus(BASE, {24'b0, 8'($urandom)}, 4'b0001, 50, rd, lat);
        bus(BASE + 32'h4, 32'h0, 4'b0000, 50, rd, lat);
        check("status_queued", rd, 32'h0000_0201);
        drain("status_b_drain");

        // Back-to-back writes overflowing the FIFO; last one stalls
        starts_q.delete();
        for (int i = 0; i < 6; i++) begin
            bus(BASE, 32'(32'h30 + i), 4'b0001, 200, rd, lat);
            if (i == 0) check("b2b_lat0", 32'(lat), 32'd1);
            else if (i < 5) check("b2b_lat", 32'(lat), 32'd2);
            else check("b2b_stall", {31'b0, lat > 20}, 32'd1);
        end
        drain("b2b_drain");
        check("b2b_frames", 32'(starts_q.size()), 32'd6);
        for (int i = 1; i < starts_q.size(); i++)
            check("b2b_gap", 32'(starts_q[i] - starts_q[i-1]), 32'(FRAME));

        // Random bytes with random spacing and upper strobes
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            bus(BASE | 32'($urandom_range(0, 3)), {24'($urandom), b},
                {3'($urandom_range(0, 7)), 1'b1}, 200, rd, lat);
            check("rand_ack", {31'b0, lat > 0}, 32'd1);
            wait_cycles($urandom_range(0, 30));
        end
        drain("rand_drain");

        // Address miss never acknowledged and queues nothing
        bus(32'h2000_0000 | 32'($urandom_range(0, 15)), 32'h55, 4'b0001, 20, rd, lat);
        check("miss_noready", 32'(lat), 32'hFFFF_FFFF);
        bus(BASE + 32'h4, 32'h0, 4'b0000, 50, rd, lat);
        check("miss_status", rd, 32'h0000_0004);
        wait_cycles(3);
        check("rdata_hold", mem_rdata, 32'h0000_0004);

        // Reserved and non-pushing accesses
        bus(BASE + 32'h8, 32'hFF, 4'b0001, 50, rd, lat);
        check("rsvd8_lat", 32'(lat), 32'd1);
        check("rsvd8_rdata", rd, 32'h0);
        bus(BASE + 32'h4, 32'h0, 4'b0000, 50, rd, lat);
        bus(BASE + 32'hC, 32'h0, 4'b0000, 50, rd, lat);
        check("rsvdC_rdata", rd, 32'h0);
        bus(BASE, 32'h0000_00AA, 4'b0010, 50, rd, lat);
        check("data_nostrb0", rd, 32'h0);
        bus(BASE, 32'h0, 4'b0000, 50, rd, lat);
        check("data_read", rd, 32'h0);
        wait_cycles(2 * FRAME);
        check("no_frame_irq", {31'b0, tx_irq}, 32'd1);
        check("no_frame_txd", {31'b0, txd}, 32'd1);

        // Reset in the middle of a frame
        bus(BASE, {24'b0, 8'($urandom)}, 4'b0001, 50, rd, lat);
        wait_cycles(15);
        check("pre_rst_busy", {31'b0, mon_active}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_txd", {31'b0, txd}, 32'd1);
        check("midrst_irq", {31'b0, tx_irq}, 32'd1);
        exp_q.delete();
        wait_cycles(3);
        reset = 1'b0;
        bus(BASE + 32'h4, 32'h0, 4'b0000, 50, rd, lat);
        check("postrst_status", rd, 32'h0000_0004);
        wait_cycles(2 * FRAME);
        check("postrst_txd", {31'b0, txd}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
